// File: rtl/rabbit_pkg.sv
// Shared constants, FSM state codes, serial line struct and frame checksum for the Rabbit receiver.
package rabbit_pkg;

    localparam int FRAME_BITS    = 184;
    localparam int CHECKSUM_BITS = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] PUSH  = 2'd3;

    typedef struct packed {
        logic sclk;
        logic sdio;
    } rabbit_line_t;

    // XOR of every byte above the trailing checksum byte.
    function automatic logic [CHECKSUM_BITS-1:0] frame_checksum(input logic [FRAME_BITS-1:0] frame);
        logic [CHECKSUM_BITS-1:0] acc;
        acc = '0;
        for (int i = 1; i < FRAME_BITS / CHECKSUM_BITS; i++)
            acc ^= frame[i*CHECKSUM_BITS +: CHECKSUM_BITS];
        return acc;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rabbit_frame_fifo.sv
// Frame queue with a registered head; head_valid/head_data lag a push by one cycle.
module rabbit_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 184
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_nxt;

    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop};

    // Head is fetched from the post-pop pointer using the pre-push write pointer,
    // so a freshly written entry becomes visible one cycle after its push.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            rd_ptr     <= rd_nxt;
            head_valid <= (wr_ptr != rd_nxt);
            if (wr_ptr != rd_nxt)
                head_data <= mem[rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rabbit_frame_controller.sv
// Rabbit serial frame receiver: SCLK/SDIO sync, frame FSM with idle timeout, frame FIFO.
// Define RABBIT_CHECKSUM_EN to drop frames whose trailing byte is not the XOR of the others.
module rabbit_frame_controller #(
    parameter int FRAME_BITS     = rabbit_pkg::FRAME_BITS,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SCLK_PE3,
    input  logic                  SDIO_PE5,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [7:0]            drop_count,
    output logic [7:0]            abort_count,
    output logic                  busy
);
    import rabbit_pkg::*;

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    rabbit_line_t [2:0]    ln_pipe;
    logic [1:0]            state;
    logic [FRAME_BITS-2:0] shreg;
    logic [FRAME_BITS-1:0] hold;
    logic [FRAME_BITS-1:0] shifted;
    logic [CW-1:0]         bit_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic                  sclk_rise;
    logic                  din;
    logic                  pass;
    logic                  pop;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  next_frame;

    // SDIO rides one stage deeper than the SCLK edge detector so it lines up with the edge.
    assign sclk_rise  = ln_pipe[1].sclk & ~ln_pipe[2].sclk;
    assign din        = ln_pipe[2].sdio;
    assign shifted    = {shreg, din};
    assign pop        = frame_valid & frame_ready & ~fifo_empty;
    assign push       = (state == PUSH) & (~fifo_full | pop);
    assign next_frame = sclk_rise | (bit_cnt != '0);
    assign busy       = (state != IDLE);

`ifdef RABBIT_CHECKSUM_EN
    assign pass = (frame_checksum(hold) == hold[CHECKSUM_BITS-1:0]);
`else
    assign pass = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ln_pipe     <= '0;
            state       <= IDLE;
            shreg       <= '0;
            hold        <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            drop_count  <= '0;
            abort_count <= '0;
        end else begin
            ln_pipe[0].sclk <= SCLK_PE3;
            ln_pipe[0].sdio <= SDIO_PE5;
            ln_pipe[2:1]    <= ln_pipe[1:0];
            tmo_cnt         <= (sclk_rise || state == IDLE) ? '0 : tmo_cnt + TW'(1);

            // Edges always shift; during CHECK/PUSH they start the next frame.
            if (sclk_rise) begin
                shreg   <= shifted[FRAME_BITS-2:0];
                bit_cnt <= bit_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (sclk_rise)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        if (bit_cnt == CW'(FRAME_BITS - 1)) begin
                            hold    <= shifted;
                            bit_cnt <= '0;
                            state   <= CHECK;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        abort_count <= sat_inc8(abort_count);
                        shreg       <= '0;
                        bit_cnt     <= '0;
                        state       <= IDLE;
                    end
                end
                CHECK: begin
                    if (pass) begin
                        state <= PUSH;
                    end else begin
                        drop_count <= sat_inc8(drop_count);
                        state      <= next_frame ? SHIFT : IDLE;
                    end
                end
                PUSH: begin
                    if (!push)
                        drop_count <= sat_inc8(drop_count);
                    state <= next_frame ? SHIFT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rabbit_frame_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(FRAME_BITS)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (push),
        .push_data (hold),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_valid(frame_valid),
        .head_data (frame_data)
    );

endmodule

// File: tb/tb_rabbit_frame_controller.sv
// Directed/randomized bench for rabbit_frame_controller with a queue-based frame model.
module tb_rabbit_frame_controller;
    localparam int FB    = 184;
    localparam int DEPTH = 4;
    localparam int TMO   = 4096;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          SCLK_PE3;
    logic          SDIO_PE5;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic [7:0]    drop_count;
    logic [7:0]    abort_count;
    logic          busy;

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    logic [FB-1:0] expq[$];
    int            exp_drop  = 0;
    int            exp_abort = 0;

    always #5 CLK = ~CLK;

    rabbit_frame_controller #(
        .FRAME_BITS    (FB),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SCLK_PE3   (SCLK_PE3),
        .SDIO_PE5   (SDIO_PE5),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .drop_count (drop_count),
        .abort_count(abort_count),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checksum computed bit by bit: bit b of the frame folds into checksum bit b%8.
    function automatic logic [7:0] ref_sum(input logic [FB-1:0] f);
        logic [7:0] s;
        s = 8'h00;
        for (int b = FB - 1; b >= 8; b--)
            s[b % 8] = s[b % 8] ^ f[b];
        return s;
    endfunction

    function automatic logic [FB-1:0] rand_frame();
        logic [FB-1:0] f;
        for (int b = 0; b < FB; b++)
            f[b] = 1'($urandom_range(0, 1));
        f[7:0] = ref_sum(f);
        return f;
    endfunction

    function automatic bit frame_ok(input logic [FB-1:0] f);
`ifdef RABBIT_CHECKSUM_EN
        return ref_sum(f) == f[7:0];
`else
        return (f === f);
`endif
    endfunction

    task automatic model_frame(input logic [FB-1:0] f);
        if (!frame_ok(f) || expq.size() >= DEPTH)
            exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        else
            expq.push_back(f);
    endtask

    // One SCLK period = 10 CLK; rise happens on a CLK falling edge.
    task automatic send_bit(input logic b);
        SDIO_PE5 = b;
        repeat (5) @(negedge CLK);
        SCLK_PE3 = 1'b1;
        repeat (5) @(negedge CLK);
        SCLK_PE3 = 1'b0;
    endtask

    task automatic send_bits(input logic [FB-1:0] f, input int n);
        for (int i = 0; i < n; i++)
            send_bit(f[FB-1-i]);
    endtask

    task automatic send_frame(input logic [FB-1:0] f);
        send_bits(f, FB);
        model_frame(f);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (expq.size() > 0 && guard < 3000) begin
            frame_ready = 1'($urandom_range(0, 1));
            if (frame_valid && frame_ready)
                chk(tag, frame_data, expq.pop_front());
            @(negedge CLK);
            guard++;
        end
        frame_ready = 1'b0;
        chk({tag, "_left"}, FB'(expq.size()), FB'(0));
        repeat (3) @(negedge CLK);
        chk({tag, "_idle_valid"}, FB'(frame_valid), FB'(0));
    endtask

    initial begin
        logic [FB-1:0] f;
        logic [FB-1:0] f5;
        int            lat;

        RESET       = 1'b1;
        SCLK_PE3    = 1'b0;
        SDIO_PE5    = 1'b0;
        frame_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", FB'(frame_valid), FB'(0));
        chk("rst_data", frame_data, '0);
        chk("rst_drop", FB'(drop_count), FB'(0));
        chk("rst_abort", FB'(abort_count), FB'(0));
        chk("rst_busy", FB'(busy), FB'(0));
        @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        // A5 pattern: latency from last rising SCLK edge to frame_valid
        f = {23{8'hA5}};
        f[7:0] = ref_sum(f);
        send_bits(f, FB - 1);
        SDIO_PE5 = f[0];
        repeat (5) @(negedge CLK);
        SCLK_PE3 = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
            if (frame_valid) break;
        end
        chk("a5_latency", FB'(lat), FB'(6));
        chk("a5_data", frame_data, f);
        repeat (4) @(negedge CLK);
        SCLK_PE3 = 1'b0;
        model_frame(f);
        chk("a5_drop", FB'(drop_count), FB'(exp_drop));
        drain("a5_pop");

        // Five back-to-back frames while downstream stalls
        for (int k = 0; k < 5; k++)
            send_frame(rand_frame());
        repeat (10) @(negedge CLK);
        chk("b2b_drop", FB'(drop_count), FB'(exp_drop));
        chk("b2b_valid", FB'(frame_valid), FB'(1));
        drain("b2b_pop");

        // Idle timeout after 100 bits, then a clean frame
        f = rand_frame();
        send_bits(f, 100);
        @(negedge CLK);
        chk("tmo_busy_mid", FB'(busy), FB'(1));
        repeat (TMO + 20) @(negedge CLK);
        exp_abort++;
        chk("tmo_abort", FB'(abort_count), FB'(exp_abort));
        chk("tmo_busy_after", FB'(busy), FB'(0));
        send_frame(rand_frame());
        repeat (10) @(negedge CLK);
        drain("tmo_next_pop");

        // Corrupted checksum byte
        f = rand_frame();
        f[0] = ~f[0];
        send_frame(f);
        repeat (10) @(negedge CLK);
        chk("csum_drop", FB'(drop_count), FB'(exp_drop));
        chk("csum_valid", FB'(frame_valid), FB'(expq.size() > 0));
        drain("csum_pop");

        // Full FIFO, pop in the same cycle as PUSH
        for (int k = 0; k < DEPTH; k++)
            send_frame(rand_frame());
        f5 = rand_frame();
        send_bits(f5, FB - 1);
        SDIO_PE5 = f5[0];
        repeat (5) @(negedge CLK);
        SCLK_PE3 = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        frame_ready = 1'b1;
        chk("full_head", frame_data, expq.pop_front());
        @(posedge CLK);
        #1;
        frame_ready = 1'b0;
        expq.push_back(f5);
        repeat (3) @(negedge CLK);
        SCLK_PE3 = 1'b0;
        repeat (6) @(negedge CLK);
        chk("full_drop", FB'(drop_count), FB'(exp_drop));
        drain("full_pop");

        // Reset mid-frame with frames queued
        send_frame(rand_frame());
        send_frame(rand_frame());
        send_bits(rand_frame(), 50);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        expq.delete();
        exp_drop  = 0;
        exp_abort = 0;
        chk("mrst_valid", FB'(frame_valid), FB'(0));
        chk("mrst_drop", FB'(drop_count), FB'(exp_drop));
        chk("mrst_abort", FB'(abort_count), FB'(exp_abort));
        chk("mrst_busy", FB'(busy), FB'(0));
        @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        send_frame(rand_frame());
        repeat (10) @(negedge CLK);
        drain("mrst_next_pop");
        chk("end_drop", FB'(drop_count), FB'(exp_drop));
        chk("end_abort", FB'(abort_count), FB'(exp_abort));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rabbit_frame_controller.md
# rabbit_frame_controller

Receives 184-bit command frames from the Rabbit microcontroller on SCLK_PE3/SDIO_PE5, re-times them into the FPGA system clock domain, enforces frame alignment with an idle timeout, and queues complete frames for the DDS update logic. It replaces free-running, SCLK-clocked capture with a sequenced front end. That front end detects lost bits, buffers back-to-back frames and hands each frame downstream over a valid/ready handshake.

## Interface
- FRAME_BITS, 184, bits per Rabbit frame
- FIFO_DEPTH, 4, frames buffered; power of two, ≥2
- TIMEOUT_CYCLES, 4096, CLK cycles of SCLK inactivity that abort a partial frame

- CLK  in  1  system clock; must be ≥8× SCLK_PE3 frequency
- RESET  in  1  synchronous, active-high reset
- SCLK_PE3  in  1  Rabbit serial clock, asynchronous to CLK
- SDIO_PE5  in  1  Rabbit serial data, valid on SCLK_PE3 rising edge
- frame_data  out  FRAME_BITS  head-of-queue frame; first bit received is MSB [183]
- frame_valid  out  1  head-of-queue frame present
- frame_ready  in  1  downstream accepts frame_data this cycle
- drop_count  out  8  frames dropped because the FIFO was full or the checksum failed; saturates at 255
- abort_count  out  8  partial frames discarded by timeout; saturates at 255
- busy  out  1  a frame is partially received

## Operation
- SCLK_PE3 and SDIO_PE5 each pass through a 2-FF synchronizer; a third SCLK stage drives rising-edge detection. SDIO is delayed one extra stage so that it samples aligned to the detected edge.
- States:
  - IDLE: on an SCLK edge, shift in bit, bit_cnt←1, go to SHIFT.
  - SHIFT: each edge shifts in one bit (shift left, new bit at LSB) and increments bit_cnt. When bit_cnt reaches FRAME_BITS, go to CHECK. If TIMEOUT_CYCLES elapse with no edge, abort_count++, clear the shifter, go to IDLE.
  - CHECK: one cycle; evaluate the checksum (see Configuration). Go to PUSH if the frame passes, else drop_count++ and go to IDLE.
  - PUSH: one cycle; write the shifter to the FIFO if it is not full, or if a pop occurs in the same cycle. Otherwise drop_count++. Go to IDLE.
- An SCLK edge arriving during CHECK or PUSH is treated as the first bit of the next frame. The shifter is copied to a holding register on entry to CHECK, which makes this safe.
- FIFO: pop occurs when frame_valid && frame_ready. Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full means the MSBs differ and the remaining bits are equal; empty means the pointers are equal.
- Counters saturate and never wrap. They clear only on RESET.

## Timing
- Reset values: frame_data 0, frame_valid 0, drop_count 0, abort_count 0, busy 0. State is IDLE and the FIFO is empty. Synchronizer flops reset to 0. An SCLK high at reset release therefore produces one spurious edge; the Rabbit holds SCLK low across reset.
- Latency: the final SCLK rising edge appears as a frame_valid rise (FIFO previously empty) 3 sync cycles + CHECK + PUSH + 1 FIFO cycle = 6 CLK cycles later.
- frame_data is stable while frame_valid=1 and no pop occurs. After a pop, the next entry appears on the following cycle.
- busy is high in SHIFT, CHECK and PUSH.
- RESET asserted mid-frame discards the partial frame and all queued frames. Bit alignment restarts on the first SCLK edge after release.

## Configuration
- RABBIT_CHECKSUM_EN defined: frame bits [7:0] must equal the XOR of the 22 preceding bytes ([183:176] … [15:8]). On mismatch the frame is dropped and drop_count increments.
- RABBIT_CHECKSUM_EN undefined: CHECK always passes and all 184 bits are forwarded unchecked. CHECK still costs one cycle so that latency is identical.

## Structure
- Shared package rabbit_pkg holds:
  - FRAME_BITS
  - CHECKSUM_BITS = 8
  - the state enum (IDLE, SHIFT, CHECK, PUSH)
  - a checksum function
- Sub-module rabbit_frame_fifo is parameterized FIFO_DEPTH × FRAME_BITS and provides push, pop, full and empty. The controller FSM, synchronizers and counters remain in the top module.

## Test plan
- Single frame, 0xA5… pattern with correct checksum, CLK = 10× SCLK → frame_valid rises 6 cycles after the last edge, frame_data bit-exact with first bit at [183], drop_count 0.
- 5 back-to-back frames with frame_ready=0, FIFO_DEPTH=4 → 4 frames queued, drop_count=1. Releasing ready pops them in arrival order.
- Stop SCLK after 100 bits for TIMEOUT_CYCLES+1 → abort_count=1, busy falls. The next full frame is received correctly.
- With RABBIT_CHECKSUM_EN, frame with bit [0] flipped → no frame_valid, drop_count=1. Without the macro, the same frame is forwarded.
- Full FIFO with frame_ready=1 in the same cycle as PUSH → frame accepted, no drop.
- RESET pulse at bit 50 of a frame with 2 frames queued → frame_valid 0 and counters 0 next cycle. The subsequent frame is received intact.
